// File: rtl/multdiv_seq_pkg.sv
// Shared types and constants for the mult/div sequencer.
// Holds state and op encodings plus the default WAIT timeout.
package multdiv_seq_pkg;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // Counter width able to reach cycles-1 with one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Clearable up-counter with a terminal-count flag.
// Saturates at the terminal value so it never wraps.
module cycle_counter
    import multdiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = cnt_width(DEF_TIMEOUT_CYCLES),
    parameter int unsigned TERMINAL = DEF_TIMEOUT_CYCLES - 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc_o = (count_q == TC_VAL);

    // Next count: clear dominates, then count up until terminal.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !tc_o) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one iterative mult/div operation on an external unit,
// stalling the pipeline until a result or a timeout is captured.
module multdiv_sequencer
    import multdiv_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        unit_resultRDY,
    input  logic [31:0] unit_result,
    input  logic        unit_exception,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        halt,
    output logic [31:0] result,
    output logic        exception,
    output logic        result_valid,
    output logic        timeout
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    state_e      state_q;
    state_e      state_d;
    op_e         op_q;
    op_e         op_d;
    logic [31:0] a_q;
    logic [31:0] a_d;
    logic [31:0] b_q;
    logic [31:0] b_d;
    logic [31:0] res_q;
    logic [31:0] res_d;
    logic        exc_q;
    logic        exc_d;
    logic        tmo_q;
    logic        tmo_d;

    logic        req;
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_tc;

    assign req = is_mult | is_div;

    cycle_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_wait_cnt (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (cnt_clr),
        .enable_i (cnt_en),
        .tc_o     (cnt_tc)
    );

    // Next-state, capture and output decode for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        exc_d        = exc_q;
        tmo_d        = tmo_q;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        result_valid = 1'b0;
        halt         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                halt = req;
                if (req) begin
                    op_d    = is_mult ? OP_MUL : OP_DIV;
                    a_d     = operand_a;
                    b_d     = operand_b;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                halt    = req;
                cnt_clr = 1'b1;
                if (!req) begin
                    // Flushed before the unit was kicked off.
                    state_d = ST_IDLE;
                end else begin
                    ctrl_MULT = (op_q == OP_MUL);
                    ctrl_DIV  = (op_q == OP_DIV);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                halt   = req;
                cnt_en = 1'b1;
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (unit_resultRDY) begin
                    res_d   = unit_result;
                    exc_d   = unit_exception;
                    state_d = ST_DONE;
                end else if (cnt_tc) begin
                    res_d   = '0;
                    exc_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                result_valid = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Stall request must drop as soon as reset is applied.
        if (!reset) begin
            halt = 1'b0;
        end
    end

    // State and captured-data registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            tmo_q   <= tmo_d;
        end
    end

    assign unit_a    = a_q;
    assign unit_b    = b_q;
    assign result    = res_q;
    assign exception = exc_q;
    assign timeout   = tmo_q;

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 40: maximum WAIT cycles before the unit is declared hung.
REQ-002 clock  in  1  master clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 is_mult  in  1  DX-stage instruction decodes as mult.
REQ-005 is_div  in  1  DX-stage instruction decodes as div.
REQ-006 operand_a  in  32  bypassed A operand.
REQ-007 operand_b  in  32  bypassed B operand.
REQ-008 unit_resultRDY  in  1  iterative multdiv unit done flag.
REQ-009 unit_result  in  32  multdiv unit result.
REQ-010 unit_exception  in  1  multdiv unit exception (overflow / divide-by-zero).
REQ-011 ctrl_MULT  out  1  one-cycle start pulse to unit, multiply.
REQ-012 ctrl_DIV  out  1  one-cycle start pulse to unit, divide.
REQ-013 unit_a, unit_b  out  32 each  operands held stable to unit for the whole operation.
REQ-014 halt  out  1  stall request to PC, FD, DX, XM latches.
REQ-015 result  out  32  captured result.
REQ-016 exception  out  1  captured exception (unit exception or timeout).
REQ-017 result_valid  out  1  result/exception valid this cycle.
REQ-018 timeout  out  1  sticky flag: a timeout occurred since reset.

Function
REQ-019 FSM states IDLE, START, WAIT, DONE.
REQ-020 IDLE: is_mult|is_div -> latch operands and op type, go START; is_mult wins if both high.
REQ-021 START: assert exactly one of ctrl_MULT/ctrl_DIV for one cycle, clear counter, go WAIT.
REQ-022 WAIT: counter increments each cycle; unit_resultRDY=1 -> capture unit_result and unit_exception, go DONE.
REQ-023 WAIT: counter reaching TIMEOUT_CYCLES-1 without RDY -> result=0, exception=1, set timeout, go DONE.
REQ-024 RDY and timeout in the same cycle: RDY wins, timeout not set.
REQ-025 DONE: result_valid=1 for exactly one cycle, halt=0, go IDLE.
REQ-026 halt = (is_mult|is_div) while state is IDLE, START or WAIT; 0 in DONE.
REQ-027 Latency: request seen in cycle 0, pulse in cycle 1, RDY in cycle k -> DONE / result_valid in cycle k+1; halt high cycles 0..k.
REQ-028 unit_resultRDY ignored in IDLE and START.
REQ-029 Request dropped (flush) in START or WAIT -> abort to IDLE, no result_valid, result unchanged.
REQ-030 Back-to-back: new request in the IDLE cycle after DONE starts a new operation; no lost or merged ops.
REQ-031 result/exception hold their last captured value outside DONE.
REQ-032 Counter width ceil(log2(TIMEOUT_CYCLES))+1; no wrap inside WAIT.

Reset
REQ-033 reset=0 asynchronously forces IDLE, counter 0, and all outputs 0 (including the timeout flag).
REQ-034 Reset mid-operation discards the operation; no start pulse or result_valid issued after release until a new request.
REQ-035 First request is accepted on the first rising edge after reset deasserts.

Structure
REQ-036 Package multdiv_seq_pkg holds the state encoding, op-type encoding (MUL, DIV), and default TIMEOUT_CYCLES constant.
REQ-037 One sub-module, cycle_counter (clear, enable, terminal-count output), instantiated once for the WAIT timer.
REQ-038 The multdiv unit itself is external; this block contains no arithmetic beyond the counter.

Verification
REQ-039 mult 6*7, RDY at cycle 34 -> single ctrl_MULT pulse in cycle 1, halt cycles 0-34, result 42 with result_valid in cycle 35.
REQ-040 div 100/7, RDY after 33 cycles -> single ctrl_DIV pulse, result 14, exception 0.
REQ-041 div 5/0, unit_exception=1 with RDY -> exception=1 and result_valid for one cycle, timeout 0.
REQ-042 mult, RDY never asserted -> DONE at WAIT count 39, result 0, exception 1, timeout 1, halt released.
REQ-043 reset pulled low in WAIT cycle 10, then released -> IDLE, all outputs 0, late RDY ignored, next mult 2*3 gives 6.
REQ-044 request dropped in WAIT cycle 5 -> IDLE, no result_valid; back-to-back mult/div pair -> two pulses and two result_valid cycles.
